// File: rtl/add_serial_ctrl.sv
// Bit-serial add/subtract sequencer: accepts two operands and runs the 1-bit
// full-add slice LSB first, once per clock, then returns the result over a handshake.
module add_serial_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds only the bits already produced; the bit being computed completes the word.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             carry_maj;
  logic [WIDTH-1:0] sum_word;

  assign s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_maj = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign sum_word  = {s_bit, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_word[WIDTH-1:1];
        carry_d  = carry_maj;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, so overflow is carry-in ^ carry-out.
          sum_d   = sum_word;
          cout_d  = carry_maj;
          ovf_d   = carry_q ^ carry_maj;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Directed bench for add_serial_ctrl (WIDTH=8): arithmetic cases, latency,
// backpressure, operand changes after accept and asynchronous reset abort.
module tb_add_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  add_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // Called at a negedge with the controller idle. Returns at a negedge: in DONE
  // when hs=0, or one cycle after the output handshake when hs=1.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] es, input logic ec, input logic eo,
                       input bit scramble, input bit hs);
    check({tag, " in_ready_pre"}, in_ready, 1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy_run"}, busy, 1);
    check({tag, " valid_run"}, out_valid, 0);
    for (int k = 1; k < W; k++) begin
      if (scramble) begin
        op_a = W'($urandom_range(255));
        op_b = W'($urandom_range(255));
        sub  = 1'($urandom_range(1));
        in_valid = 1'($urandom_range(1));
      end
      @(negedge clk);
      check({tag, " busy_run"}, busy, 1);
      check({tag, " valid_run"}, out_valid, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " latency_valid"}, out_valid, 1);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, eo);
    $display("op %s: a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h cout=%0d ovf=%0d",
             tag, a, b, s, sum, cout, ovf);
    if (hs) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " valid_cleared"}, out_valid, 0);
      check({tag, " in_ready_post"}, in_ready, 1);
      check({tag, " sum_kept"}, sum, es);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    check("rst ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_3c_15", 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0, 0, 1);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1);
    do_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1);
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1);
    do_op("sub_10_10", 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1);

    // Backpressure: result held in DONE while new requests are offered.
    do_op("bp_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      op_a = 8'hAA ^ W'(k); op_b = 8'h55; sub = 1'(k);
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp sum", sum, 8'h46);
      check("bp in_ready", in_ready, 0);
      $display("bp cycle %0d: out_valid=%0d sum=0x%02h in_ready=%0d", k, out_valid, sum, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    check("bp not accepted", busy, 0);
    do_op("b2b_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1);

    do_op("chg_0a_0b", 8'h0A, 8'h0B, 1'b0, 8'h15, 1'b0, 1'b0, 1, 1);

    // Asynchronous reset during the third RUN cycle.
    op_a = 8'h3C; op_b = 8'h15; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst out_valid", out_valid, 0);
    check("arst busy", busy, 0);
    check("arst sum", sum, 0);
    check("arst in_ready", in_ready, 1);
    $display("arst: out_valid=%0d busy=%0d sum=0x%02h in_ready=%0d", out_valid, busy, sum, in_ready);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("arst no_stale_valid", out_valid, 0);
      check("arst idle", busy, 0);
    end
    do_op("post_22_11", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
